ann_sequencer: RTL and testbench

ANN_SEQUENCER -- requirements
Module: ann_sequencer

---
 rtl/ann_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_ann_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_sequencer.sv
// ann_sequencer
// Control sequencer for a small fully connected ANN (NEURONS neurons, N_INPUTS
// inputs each). It consumes one word stream per inference in a fixed order:
//   N_INPUTS pixels, then for each neuron: bias LSB, bias MSB, N_INPUTS weights.
// It drives the datapath strobes for each word and each housekeeping step,
// then captures the predicted digit returned by the ANN.
//
// Optional feature: define ANN_SEQ_ABORT_EN to let 'abort' cancel a running
// inference. Without it, 'abort' is ignored and 'aborted' stays 0.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   start                  begin an inference (only honoured when idle)
//   s_data/s_valid/s_ready input word stream (pixels, biases, weights)
//   abort                  cancel the running inference (ANN_SEQ_ABORT_EN)
//   rst_sum .. ld_max_func one-cycle ANN control strobes
//   ld_neuron              neuron index presented with rst_sum / ReLU
//   ann_in                 last accepted data word, forwarded to the ANN
//   number_in              digit predicted by the ANN
//   result/result_valid    captured digit and its one-cycle qualifier
//   busy, aborted          status flags
module ann_sequencer #(
   parameter int NEURONS  = 10,
   parameter int N_INPUTS = 32
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start,
   input  logic [15:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        abort,
   output logic        rst_sum,
   output logic        ld_in,
   output logic        ld_weight,
   output logic        shift_in,
   output logic        ld_multiplication,
   output logic        ld_bias_LSB,
   output logic        ld_bias_MSB,
   output logic        bias_addition,
   output logic        ReLU_computation,
   output logic        ld_max_func,
   output logic [3:0]  ld_neuron,
   output logic [15:0] ann_in,
   input  logic [3:0]  number_in,
   output logic [3:0]  result,
   output logic        result_valid,
   output logic        busy,
   output logic        aborted
);

   typedef enum logic [3:0] {
      IDLE, LOAD_IN, CLR, BIAS_L, BIAS_H, MAC, BIAS_ADD, RELU, MAX, CAPTURE
   } state_t;

   localparam logic [5:0] LAST_WORD   = 6'(N_INPUTS - 1);
   localparam logic [3:0] LAST_NEURON = 4'(NEURONS - 1);

   state_t     state;
   logic [5:0] word_cnt;
   logic [3:0] neuron_cnt;
   logic       accept;
   logic       abort_hit;

   // s_ready is registered, so it already reflects the current state.
   assign accept = s_valid & s_ready;

`ifdef ANN_SEQ_ABORT_EN
   assign abort_hit = abort & (state != IDLE);
`else
   logic abort_unused;
   assign abort_unused = abort;
   assign abort_hit    = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state             <= IDLE;
         word_cnt          <= '0;
         neuron_cnt        <= '0;
         s_ready           <= 1'b0;
         rst_sum           <= 1'b0;
         ld_in             <= 1'b0;
         ld_weight         <= 1'b0;
         shift_in          <= 1'b0;
         ld_multiplication <= 1'b0;
         ld_bias_LSB       <= 1'b0;
         ld_bias_MSB       <= 1'b0;
         bias_addition     <= 1'b0;
         ReLU_computation  <= 1'b0;
         ld_max_func       <= 1'b0;
         ld_neuron         <= '0;
         ann_in            <= '0;
         result            <= '0;
         result_valid      <= 1'b0;
         busy              <= 1'b0;
         aborted           <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses; default them low every cycle.
         rst_sum           <= 1'b0;
         ld_in             <= 1'b0;
         ld_weight         <= 1'b0;
         shift_in          <= 1'b0;
         ld_multiplication <= 1'b0;
         ld_bias_LSB       <= 1'b0;
         ld_bias_MSB       <= 1'b0;
         bias_addition     <= 1'b0;
         ReLU_computation  <= 1'b0;
         ld_max_func       <= 1'b0;
         result_valid      <= 1'b0;

         if (abort_hit) begin
            // Abort wins over any word offered in the same cycle.
            state      <= IDLE;
            word_cnt   <= '0;
            neuron_cnt <= '0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            aborted    <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state      <= LOAD_IN;
                     word_cnt   <= '0;
                     neuron_cnt <= '0;
                     s_ready    <= 1'b1;
                     busy       <= 1'b1;
                     aborted    <= 1'b0;
                  end
               end
               LOAD_IN: begin
                  if (accept) begin
                     ld_in  <= 1'b1;
                     ann_in <= s_data;
                     if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        s_ready  <= 1'b0;
                        state    <= CLR;
                     end else begin
                        word_cnt <= word_cnt + 6'd1;
                     end
                  end
               end
               CLR: begin
                  rst_sum   <= 1'b1;
                  ld_neuron <= neuron_cnt;
                  s_ready   <= 1'b1;
                  state     <= BIAS_L;
               end
               BIAS_L: begin
                  if (accept) begin
                     ld_bias_LSB <= 1'b1;
                     ann_in      <= s_data;
                     state       <= BIAS_H;
                  end
               end
               BIAS_H: begin
                  if (accept) begin
                     ld_bias_MSB <= 1'b1;
                     ann_in      <= s_data;
                     state       <= MAC;
                  end
               end
               MAC: begin
                  if (accept) begin
                     ld_weight         <= 1'b1;
                     shift_in          <= 1'b1;
                     ld_multiplication <= 1'b1;
                     ann_in            <= s_data;
                     if (word_cnt == LAST_WORD) begin
                        word_cnt <= '0;
                        s_ready  <= 1'b0;
                        state    <= BIAS_ADD;
                     end else begin
                        word_cnt <= word_cnt + 6'd1;
                     end
                  end
               end
               BIAS_ADD: begin
                  bias_addition <= 1'b1;
                  state         <= RELU;
               end
               RELU: begin
                  ReLU_computation <= 1'b1;
                  ld_neuron        <= neuron_cnt;
                  if (neuron_cnt == LAST_NEURON) begin
                     neuron_cnt <= '0;
                     state      <= MAX;
                  end else begin
                     neuron_cnt <= neuron_cnt + 4'd1;
                     state      <= CLR;
                  end
               end
               MAX: begin
                  ld_max_func <= 1'b1;
                  state       <= CAPTURE;
               end
               CAPTURE: begin
                  result       <= number_in;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
               default: begin
                  state   <= IDLE;
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ann_sequencer.sv
// tb_ann_sequencer
// Drives random word streams into ann_sequencer and compares every strobe
// against an ordered list of expected events derived from the word layout
// of one inference. A second instance with NEURONS=1 covers the single
// neuron case.
module tb_ann_sequencer;

   localparam int NI    = 32;
   localparam int NN    = 10;
   localparam int TOTAL = NI + NN * (NI + 2);

   localparam logic [3:0] K_LDIN = 4'd0;
   localparam logic [3:0] K_RST  = 4'd1;
   localparam logic [3:0] K_BL   = 4'd2;
   localparam logic [3:0] K_BH   = 4'd3;
   localparam logic [3:0] K_MAC  = 4'd4;
   localparam logic [3:0] K_BADD = 4'd5;
   localparam logic [3:0] K_RELU = 4'd6;
   localparam logic [3:0] K_MAX  = 4'd7;
   localparam logic [3:0] K_RES  = 4'd8;

   logic        clk;
   logic        wb_rst_i;
   logic        start, s_valid, s_ready, abort;
   logic [15:0] s_data;
   logic        rst_sum, ld_in, ld_weight, shift_in, ld_multiplication;
   logic        ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation, ld_max_func;
   logic [3:0]  ld_neuron, number_in, result;
   logic [15:0] ann_in;
   logic        result_valid, busy, aborted;

   logic        start1, s_valid1, s_ready1, abort1;
   logic [15:0] s_data1;
   logic        rst_sum1, ld_in1, ld_weight1, shift_in1, ld_multiplication1;
   logic        ld_bias_LSB1, ld_bias_MSB1, bias_addition1, ReLU_computation1, ld_max_func1;
   logic [3:0]  ld_neuron1, number_in1, result1;
   logic [15:0] ann_in1;
   logic        result_valid1, busy1, aborted1;

   int n_checks = 0;
   int n_errors = 0;

   ann_sequencer #(.NEURONS(NN), .N_INPUTS(NI)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .abort(abort),
      .rst_sum(rst_sum), .ld_in(ld_in), .ld_weight(ld_weight), .shift_in(shift_in),
      .ld_multiplication(ld_multiplication), .ld_bias_LSB(ld_bias_LSB),
      .ld_bias_MSB(ld_bias_MSB), .bias_addition(bias_addition),
      .ReLU_computation(ReLU_computation), .ld_max_func(ld_max_func),
      .ld_neuron(ld_neuron), .ann_in(ann_in), .number_in(number_in),
      .result(result), .result_valid(result_valid), .busy(busy), .aborted(aborted)
   );

   ann_sequencer #(.NEURONS(1), .N_INPUTS(NI)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start1),
      .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1), .abort(abort1),
      .rst_sum(rst_sum1), .ld_in(ld_in1), .ld_weight(ld_weight1), .shift_in(shift_in1),
      .ld_multiplication(ld_multiplication1), .ld_bias_LSB(ld_bias_LSB1),
      .ld_bias_MSB(ld_bias_MSB1), .bias_addition(bias_addition1),
      .ReLU_computation(ReLU_computation1), .ld_max_func(ld_max_func1),
      .ld_neuron(ld_neuron1), .ann_in(ann_in1), .number_in(number_in1),
      .result(result1), .result_valid(result_valid1), .busy(busy1), .aborted(aborted1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic abort_active();
`ifdef ANN_SEQ_ABORT_EN
      return abort;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [9:0] strobes();
      return {rst_sum, ld_in, ld_weight, shift_in, ld_multiplication,
              ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation, ld_max_func};
   endfunction

   // Reference model: the ordered list of events one inference must produce.
   logic [15:0] words [TOTAL];
   logic [19:0] exp_q [$];
   int          ev_cnt [9];
   logic        mon_en = 1'b0;
   logic        mon_acc = 1'b0;
   int          words_acc;
   logic [3:0]  last_result = 4'd0;

   task automatic gen_words();
      foreach (words[i]) words[i] = 16'($urandom);
   endtask

   task automatic build_expect(input logic [3:0] num);
      exp_q.delete();
      for (int i = 0; i < NI; i++) exp_q.push_back({K_LDIN, words[i]});
      for (int n = 0; n < NN; n++) begin
         int base = NI + n * (NI + 2);
         exp_q.push_back({K_RST, 16'(n)});
         exp_q.push_back({K_BL, words[base]});
         exp_q.push_back({K_BH, words[base + 1]});
         for (int k = 0; k < NI; k++) exp_q.push_back({K_MAC, words[base + 2 + k]});
         exp_q.push_back({K_BADD, 16'd0});
         exp_q.push_back({K_RELU, 16'(n)});
      end
      exp_q.push_back({K_MAX, 16'd0});
      exp_q.push_back({K_RES, 16'(num)});
   endtask

   task automatic take_event(input logic [3:0] kind, input logic [15:0] data);
      logic [19:0] e;
      ev_cnt[kind]++;
      if (exp_q.size() == 0) begin
         check("event_extra", {12'd0, kind, data}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e[19:16]));
         check("event_data", 32'(data), 32'(e[15:0]));
      end
   endtask

   always @(negedge clk) begin : monitor
      logic word_strobe;
      word_strobe = ld_in | ld_bias_LSB | ld_bias_MSB | ld_weight;
      if (mon_en) begin
         check("strobe_follows_accept", 32'(word_strobe), 32'(mon_acc));
         if (ld_weight | shift_in | ld_multiplication)
            check("mac_trio", 32'({ld_weight, shift_in, ld_multiplication}), 32'd7);
         if (ld_in)            take_event(K_LDIN, ann_in);
         if (rst_sum)          take_event(K_RST, 16'(ld_neuron));
         if (ld_bias_LSB)      take_event(K_BL, ann_in);
         if (ld_bias_MSB)      take_event(K_BH, ann_in);
         if (ld_weight)        take_event(K_MAC, ann_in);
         if (bias_addition)    take_event(K_BADD, 16'd0);
         if (ReLU_computation) take_event(K_RELU, 16'(ld_neuron));
         if (ld_max_func)      take_event(K_MAX, 16'd0);
         if (result_valid)     take_event(K_RES, 16'(result));
      end
      mon_acc = s_valid & s_ready & ~abort_active();
   end

   // evt_kind: 0 none, 1 reset once evt_at words accepted, 2 abort at word evt_at
   task automatic run_inf(input int mode, input int evt_at, input int evt_kind, output bit done);
      int idx;
      bit acc, fired;
      idx = 0; fired = 0; done = 0;
      foreach (ev_cnt[k]) ev_cnt[k] = 0;
      @(posedge clk); #1;
      start = 1'b1; s_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_s_ready", 32'(s_ready), 32'd1);
      check("start_aborted_clr", 32'(aborted), 32'd0);
      check("result_held", 32'(result), 32'(last_result));
      mon_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         s_valid = 1'b0;
         if (idx < TOTAL) begin
            case (mode)
               0:       s_valid = 1'b1;
               1:       s_valid = ((c % 3) != 2);
               default: s_valid = ($urandom_range(3) != 0);
            endcase
            s_data = words[idx];
         end
         if (mode == 2) start = 1'($urandom_range(1));
         if (evt_kind == 2 && !fired && idx == evt_at) begin
            abort = 1'b1;
            fired = 1;
         end
         acc = s_valid && s_ready && !abort_active();
         @(posedge clk);
         if (acc) idx++;
         #1;
         abort = 1'b0;
         if (result_valid) begin
            done = 1;
            break;
         end
         if (evt_kind == 2 && fired && !busy) break;
         if (evt_kind == 1 && idx == evt_at) begin
            #1;
            wb_rst_i = 1'b1;
            mon_en = 1'b0;
            #1;
            check("async_rst_strobes", 32'(strobes()), 32'd0);
            check("async_rst_busy", 32'(busy), 32'd0);
            check("async_rst_s_ready", 32'(s_ready), 32'd0);
            check("async_rst_ld_neuron", 32'(ld_neuron), 32'd0);
            check("async_rst_ann_in", 32'(ann_in), 32'd0);
            check("async_rst_result", 32'(result), 32'd0);
            break;
         end
      end
      start = 1'b0;
      s_valid = 1'b0;
      words_acc = idx;
   endtask

   task automatic finish_run(input logic [3:0] num);
      @(negedge clk); #1;
      check("words_accepted", 32'(words_acc), 32'(TOTAL));
      check("cnt_ld_in", 32'(ev_cnt[K_LDIN]), 32'(NI));
      check("cnt_rst_sum", 32'(ev_cnt[K_RST]), 32'(NN));
      check("cnt_bias_l", 32'(ev_cnt[K_BL]), 32'(NN));
      check("cnt_ld_weight", 32'(ev_cnt[K_MAC]), 32'(NN * NI));
      check("cnt_relu", 32'(ev_cnt[K_RELU]), 32'(NN));
      check("cnt_max", 32'(ev_cnt[K_MAX]), 32'd1);
      check("cnt_result_valid", 32'(ev_cnt[K_RES]), 32'd1);
      check("events_left", 32'(exp_q.size()), 32'd0);
      check("result", 32'(result), 32'(num));
      check("busy_after", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("result_hold", 32'(result), 32'(num));
      end
      mon_en = 1'b0;
      last_result = num;
   endtask

   task automatic full_run(input int mode, input logic [3:0] num);
      bit d;
      number_in = num;
      gen_words();
      build_expect(num);
      run_inf(mode, 0, 0, d);
      check("inference_done", 32'(d), 32'd1);
      finish_run(num);
   endtask

   // Single-neuron instance observation.
   logic mon1_en = 1'b0;
   int   relu1_cnt, max1_cnt, rst1_cnt, cyc1, relu1_cyc, max1_cyc;
   logic nz1;
   always @(negedge clk) begin
      if (mon1_en) begin
         cyc1++;
         if (ld_neuron1 != 4'd0) nz1 = 1'b1;
         if (rst_sum1) rst1_cnt++;
         if (ReLU_computation1) begin relu1_cnt++; relu1_cyc = cyc1; end
         if (ld_max_func1) begin max1_cnt++; max1_cyc = cyc1; end
      end
   end

   initial begin : stim
      bit d;
      int w1;
      bit acc1, done1;
      wb_rst_i = 1'b1;
      start = 1'b0; s_valid = 1'b0; s_data = '0; abort = 1'b0; number_in = 4'd0;
      start1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0; abort1 = 1'b0; number_in1 = 4'd0;

      // Reset held for three cycles, then idle with start low.
      repeat (3) @(posedge clk);
      #1 wb_rst_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_strobes", 32'(strobes()), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_ann_in", 32'(ann_in), 32'd0);
      check("rst_ld_neuron", 32'(ld_neuron), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);

      // Continuous stream, then every third cycle stalled, then random stalls.
      full_run(0, 4'd7);
      full_run(1, 4'd7);
      full_run(2, 4'($urandom_range(15)));
      full_run(2, 4'($urandom_range(15)));

      // Reset during MAC of neuron 4, then a fresh inference.
      number_in = 4'd3;
      gen_words();
      build_expect(4'd3);
      run_inf(0, NI + 4 * (NI + 2) + 12, 1, d);
      repeat (2) @(posedge clk);
      #1 wb_rst_i = 1'b0;
      last_result = 4'd0;
      full_run(0, 4'($urandom_range(15)));

      // Abort at word 100.
      number_in = 4'($urandom_range(15));
      gen_words();
      build_expect(number_in);
      run_inf(0, 100, 2, d);
`ifdef ANN_SEQ_ABORT_EN
      check("abort_no_result", 32'(d), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_flag", 32'(aborted), 32'd1);
      check("abort_s_ready", 32'(s_ready), 32'd0);
      check("abort_strobes", 32'(strobes()), 32'd0);
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_result_valid", 32'(result_valid), 32'd0);
         check("abort_sticky", 32'(aborted), 32'd1);
      end
      full_run(0, 4'($urandom_range(15)));
`else
      check("abort_ignored_done", 32'(d), 32'd1);
      check("abort_flag_low", 32'(aborted), 32'd0);
      finish_run(number_in);
`endif

      // Single neuron instance.
      number_in1 = 4'($urandom_range(15));
      relu1_cnt = 0; max1_cnt = 0; rst1_cnt = 0; cyc1 = 0;
      relu1_cyc = 0; max1_cyc = 0; nz1 = 1'b0;
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      mon1_en = 1'b1;
      w1 = 0; done1 = 0;
      for (int c = 0; c < 500; c++) begin
         s_valid1 = 1'b1;
         s_data1 = 16'($urandom);
         acc1 = s_valid1 && s_ready1;
         @(posedge clk);
         if (acc1) w1++;
         #1;
         if (result_valid1) begin
            done1 = 1;
            break;
         end
      end
      s_valid1 = 1'b0;
      @(negedge clk); #1;
      mon1_en = 1'b0;
      check("n1_done", 32'(done1), 32'd1);
      check("n1_words", 32'(w1), 32'(2 * NI + 2));
      check("n1_relu_cnt", 32'(relu1_cnt), 32'd1);
      check("n1_rst_sum_cnt", 32'(rst1_cnt), 32'd1);
      check("n1_max_cnt", 32'(max1_cnt), 32'd1);
      check("n1_relu_before_max", 32'(relu1_cyc < max1_cyc), 32'd1);
      check("n1_ld_neuron_zero", 32'(nz1), 32'd0);
      check("n1_result", 32'(result1), 32'(number_in1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
